// File: rtl/collision_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : collision_scheduler
// Purpose  : Time-multiplexed collision checker for the tank playfield. On a
//            frame_start pulse it walks every (object, wall) pair through one
//            shared axis-aligned overlap comparator, testing each object at
//            its proposed next position, and publishes one blocked bit per
//            object in hit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   Clk, Reset_n            clock (rising edge), async active-low reset
//   frame_start             one-cycle pulse that starts a scan
//   obj_sel                 index of the object currently being read
//   obj_x/y/w/h, obj_dx/dy  selected object rectangle and signed step
//   wall_sel                index of the wall currently being read
//   wall_x/y/w/h            selected wall rectangle
//   busy                    high from scan start until the result is posted
//   done                    one-cycle pulse when hit is updated
//   hit                     bit i set: object i collides at its next position
//   overrun                 sticky: frame_start arrived while busy
// Configuration:
//   COLLISION_EARLY_EXIT_EN  when defined, an object's remaining walls are
//                            skipped once it is known to be blocked.
// ============================================================================
module collision_scheduler #(
    parameter int NUM_OBJ   = 4,
    parameter int NUM_WALLS = 4,
    parameter int OBJ_BITS  = 2,
    parameter int WALL_BITS = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_start,
    output logic [OBJ_BITS-1:0]  obj_sel,
    input  logic [9:0]           obj_x,
    input  logic [9:0]           obj_y,
    input  logic [9:0]           obj_w,
    input  logic [9:0]           obj_h,
    input  logic [9:0]           obj_dx,
    input  logic [9:0]           obj_dy,
    output logic [WALL_BITS-1:0] wall_sel,
    input  logic [9:0]           wall_x,
    input  logic [9:0]           wall_y,
    input  logic [9:0]           wall_w,
    input  logic [9:0]           wall_h,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_OBJ-1:0]   hit,
    output logic                 overrun
);

    localparam logic [OBJ_BITS-1:0]  LAST_OBJ  = OBJ_BITS'(NUM_OBJ - 1);
    localparam logic [WALL_BITS-1:0] LAST_WALL = WALL_BITS'(NUM_WALLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [NUM_OBJ-1:0] acc;

    // ------------------------------------------------------------------
    // Shared overlap comparator. Positions are widened to 11 bits so the
    // signed step can drive the next position below zero (bit 10 set),
    // and so right/bottom edge sums never wrap.
    // ------------------------------------------------------------------
    logic [10:0] nx, ny;
    logic [10:0] obj_r, obj_b, wall_r, wall_b;
    logic        off_screen, overlap, pair_hit;

    always_comb begin
        nx         = {1'b0, obj_x} + {obj_dx[9], obj_dx};
        ny         = {1'b0, obj_y} + {obj_dy[9], obj_dy};
        obj_r      = nx + {1'b0, obj_w};
        obj_b      = ny + {1'b0, obj_h};
        wall_r     = {1'b0, wall_x} + {1'b0, wall_w};
        wall_b     = {1'b0, wall_y} + {1'b0, wall_h};
        off_screen = nx[10] | ny[10];
        // Strict compares: edges that merely touch do not overlap.
        overlap    = (nx < wall_r) && ({1'b0, wall_x} < obj_r) &&
                     (ny < wall_b) && ({1'b0, wall_y} < obj_b);
        pair_hit   = off_screen | overlap;
    end

    // ------------------------------------------------------------------
    // Early exit: a blocked object needs no further walls, so treat the
    // current wall as its last one.
    // ------------------------------------------------------------------
    logic skip_rest;
`ifdef COLLISION_EARLY_EXIT_EN
    assign skip_rest = pair_hit;
`else
    assign skip_rest = 1'b0;
`endif

    logic wall_wrap;
    logic last_pair;

    assign wall_wrap = (wall_sel == LAST_WALL) || skip_rest;
    assign last_pair = wall_wrap && (obj_sel == LAST_OBJ);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control decode
    // ------------------------------------------------------------------
    logic start_scan;
    logic scanning;
    logic post_result;

    always_comb begin
        next_state  = state;
        busy        = 1'b0;
        start_scan  = 1'b0;
        scanning    = 1'b0;
        post_result = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    start_scan = 1'b1;
                    next_state = SCAN;
                end
            end
            SCAN: begin
                busy     = 1'b1;
                scanning = 1'b1;
                if (last_pair) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                post_result = 1'b1;
                next_state  = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Index counters and hit accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            obj_sel  <= '0;
            wall_sel <= '0;
            acc      <= '0;
        end else if (start_scan) begin
            obj_sel  <= '0;
            wall_sel <= '0;
            acc      <= '0;
        end else if (scanning) begin
            if (pair_hit) begin
                acc[obj_sel] <= 1'b1;
            end
            if (wall_wrap) begin
                wall_sel <= '0;
                // Park on object 0 after the final pair so the selects
                // are idle-clean until the next scan.
                obj_sel  <= last_pair ? '0 : obj_sel + 1'b1;
            end else begin
                wall_sel <= wall_sel + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result, done pulse and overrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit     <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= post_result;
            if (post_result) begin
                hit <= acc;
            end
            // A start request is only honoured in IDLE; anywhere else it
            // is dropped and remembered until reset.
            if (frame_start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_collision_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_collision_scheduler
// Purpose  : Self-checking bench for collision_scheduler. Table of playfield
//            scenarios with hand-computed hit masks, plus directed sequences
//            for overrun, start-during-DONE and mid-scan reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_collision_scheduler;

    logic       Clk;
    logic       Reset_n;
    logic       frame_start;
    logic [1:0] obj_sel;
    logic [1:0] wall_sel;
    logic [9:0] obj_x, obj_y, obj_w, obj_h, obj_dx, obj_dy;
    logic [9:0] wall_x, wall_y, wall_w, wall_h;
    logic       busy, done, overrun;
    logic [3:0] hit;

    logic [9:0] ox[4], oy[4], ow[4], oh[4], odx[4], ody[4];
    logic [9:0] wx[4], wy[4], ww[4], wh[4];

    assign obj_x  = ox[obj_sel];
    assign obj_y  = oy[obj_sel];
    assign obj_w  = ow[obj_sel];
    assign obj_h  = oh[obj_sel];
    assign obj_dx = odx[obj_sel];
    assign obj_dy = ody[obj_sel];
    assign wall_x = wx[wall_sel];
    assign wall_y = wy[wall_sel];
    assign wall_w = ww[wall_sel];
    assign wall_h = wh[wall_sel];

    collision_scheduler #(
        .NUM_OBJ  (4),
        .NUM_WALLS(4),
        .OBJ_BITS (2),
        .WALL_BITS(2)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_start(frame_start),
        .obj_sel    (obj_sel),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_w      (obj_w),
        .obj_h      (obj_h),
        .obj_dx     (obj_dx),
        .obj_dy     (obj_dy),
        .wall_sel   (wall_sel),
        .wall_x     (wall_x),
        .wall_y     (wall_y),
        .wall_w     (wall_w),
        .wall_h     (wall_h),
        .busy       (busy),
        .done       (done),
        .hit        (hit),
        .overrun    (overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One scenario: object idx moved to the given rectangle/step and wall 0
    // placed as given; everything else stays at the baseline.
    typedef struct {
        int         idx;
        logic [9:0] x, y, w, h, dx, dy;
        logic [9:0] wx0, wy0, ww0, wh0;
        logic [3:0] exp_hit;
        string      name;
    } vec_t;

    vec_t vt[12];

    task automatic set_baseline();
        for (int i = 0; i < 4; i++) begin
            ox[i] = 10'd100; oy[i] = 10'd100; ow[i] = 10'd16; oh[i] = 10'd16;
            odx[i] = 10'd1;  ody[i] = 10'd0;
            wx[i] = 10'd300; wy[i] = 10'd300; ww[i] = 10'd20; wh[i] = 10'd20;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Pulse frame_start so it is sampled at the next edge (T), then count
    // edges after T until done is seen. Returns 0 on timeout.
    task automatic run_scan(output int lat);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        frame_start = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    int lat;
    int done_cnt;

    initial begin
        vt[0]  = '{0, 10'd100, 10'd100, 10'd16, 10'd16, 10'd1,   10'd0,   10'd300, 10'd300, 10'd20, 10'd20, 4'b0000, "clear_path"};
        vt[1]  = '{0, 10'd283, 10'd300, 10'd16, 10'd16, 10'd1,   10'd0,   10'd300, 10'd300, 10'd20, 10'd20, 4'b0000, "right_touch"};
        vt[2]  = '{0, 10'd283, 10'd300, 10'd16, 10'd16, 10'd2,   10'd0,   10'd300, 10'd300, 10'd20, 10'd20, 4'b0001, "right_overlap"};
        vt[3]  = '{2, 10'd1,   10'd100, 10'd16, 10'd16, 10'h3FE, 10'd0,   10'd300, 10'd300, 10'd20, 10'd20, 4'b0100, "neg_x_offscreen"};
        vt[4]  = '{3, 10'd1023,10'd100, 10'd16, 10'd16, 10'd0,   10'd0,   10'd300, 10'd300, 10'd20, 10'd20, 4'b0000, "x1023_no_wrap"};
        vt[5]  = '{3, 10'd1020,10'd100, 10'd16, 10'd16, 10'd0,   10'd0,   10'd1000,10'd100, 10'd23, 10'd20, 4'b1000, "right_sum_no_wrap"};
        vt[6]  = '{1, 10'd300, 10'd283, 10'd16, 10'd16, 10'd0,   10'd1,   10'd300, 10'd300, 10'd20, 10'd20, 4'b0000, "bottom_touch"};
        vt[7]  = '{1, 10'd300, 10'd283, 10'd16, 10'd16, 10'd0,   10'd2,   10'd300, 10'd300, 10'd20, 10'd20, 4'b0010, "bottom_overlap"};
        vt[8]  = '{0, 10'd321, 10'd300, 10'd16, 10'd16, 10'h3FF, 10'd0,   10'd300, 10'd300, 10'd20, 10'd20, 4'b0000, "left_touch"};
        vt[9]  = '{0, 10'd321, 10'd300, 10'd16, 10'd16, 10'h3FE, 10'd0,   10'd300, 10'd300, 10'd20, 10'd20, 4'b0001, "left_overlap"};
        vt[10] = '{1, 10'd100, 10'd0,   10'd16, 10'd16, 10'd1,   10'h3FF, 10'd300, 10'd300, 10'd20, 10'd20, 4'b0010, "neg_y_offscreen"};
        vt[11] = '{0, 10'd100, 10'd100, 10'd16, 10'd16, 10'd1,   10'd0,   10'd90,  10'd90,  10'd20, 10'd20, 4'b1111, "all_hit_wall0"};

        Reset_n = 1'b1;
        frame_start = 1'b0;
        set_baseline();
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_obj_sel", 32'(obj_sel), 32'd0);
        check("rst_wall_sel", 32'(wall_sel), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();

        // ---------------- table-driven scenarios ----------------
        for (int v = 0; v < 12; v++) begin
            set_baseline();
            ox[vt[v].idx]  = vt[v].x;  oy[vt[v].idx]  = vt[v].y;
            ow[vt[v].idx]  = vt[v].w;  oh[vt[v].idx]  = vt[v].h;
            odx[vt[v].idx] = vt[v].dx; ody[vt[v].idx] = vt[v].dy;
            wx[0] = vt[v].wx0; wy[0] = vt[v].wy0; ww[0] = vt[v].ww0; wh[0] = vt[v].wh0;
            run_scan(lat);
            check({vt[v].name, "_latency"}, 32'(lat), 32'd17);
            check({vt[v].name, "_hit"}, 32'(hit), 32'(vt[v].exp_hit));
            tick();
            check({vt[v].name, "_done_pulse"}, 32'(done), 32'd0);
            check({vt[v].name, "_idle"}, 32'(busy), 32'd0);
        end
        check("no_overrun_yet", 32'(overrun), 32'd0);

        // hit holds between scans
        for (int i = 0; i < 5; i++) tick();
        check("hit_holds", 32'(hit), 32'b1111);

        // ---------------- overrun during SCAN ----------------
        set_baseline();
        frame_start = 1'b1;
        tick();                       // edge T
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("busy_mid_scan", 32'(busy), 32'd1);
        frame_start = 1'b1;           // sampled at T+5
        tick();
        frame_start = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        lat = 0;
        for (int n = 6; n <= 40; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        check("overrun_latency", 32'(lat), 32'd17);
        check("overrun_hit", 32'(hit), 32'b0000);
        done_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("no_second_scan", 32'(done_cnt), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // ---------------- frame_start while in DONE ----------------
        do_reset();
        check("overrun_cleared", 32'(overrun), 32'd0);
        frame_start = 1'b1;
        tick();                       // edge T
        frame_start = 1'b0;
        for (int i = 0; i < 16; i++) tick();   // now in DONE
        frame_start = 1'b1;           // sampled at T+17
        tick();
        frame_start = 1'b0;
        check("done_state_done_pulse", 32'(done), 32'd1);
        check("done_state_overrun", 32'(overrun), 32'd1);
        tick();
        check("done_state_no_restart", 32'(busy), 32'd0);

        // ---------------- reset mid-scan ----------------
        do_reset();
        set_baseline();
        ox[0] = 10'd283; oy[0] = 10'd300; odx[0] = 10'd2;
        run_scan(lat);
        check("pre_reset_hit", 32'(hit), 32'b0001);
        tick();
        frame_start = 1'b1;
        tick();                       // edge T
        frame_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        Reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hit", 32'(hit), 32'd0);
        check("midrst_obj_sel", 32'(obj_sel), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        odx[0] = 10'd1;
        odx[2] = 10'h3FE; ox[2] = 10'd1;
        run_scan(lat);
        check("post_reset_latency", 32'(lat), 32'd17);
        check("post_reset_hit", 32'(hit), 32'b0100);
        check("post_reset_overrun", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
